// File: rtl/mips_hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage MIPS pipeline: shadow EXE/MEM/WB
// slots drive load-use/RAW stalls, taken-branch flushes and EXE forward selects.
module mips_hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          FWD_EN     = 1'b1,
  parameter bit          WB_BYPASS  = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  idValid,
  input  logic [REG_ADDR_W-1:0] idRs,
  input  logic [REG_ADDR_W-1:0] idRt,
  input  logic                  idUsesRs,
  input  logic                  idUsesRt,
  input  logic                  idRegWrite,
  input  logic [REG_ADDR_W-1:0] idWriteReg,
  input  logic                  idMemRead,
  input  logic                  exBranchTaken,
  output logic                  pcWrite,
  output logic                  ifIdWrite,
  output logic                  ifIdFlush,
  output logic                  idExeFlush,
  output logic [1:0]            fwdA,
  output logic [1:0]            fwdB,
  output logic [CNT_W-1:0]      stallCount,
  output logic [CNT_W-1:0]      flushCount
);

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  mem_read;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
  } slot_t;

  slot_t ex_slot, mem_slot, wb_slot, ex_next;
  logic  br_taken, stall, load_use, raw_stall, rs_used, rt_used;
  logic  unused_fields;

  function automatic logic writes(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.valid & s.reg_write & (s.write_reg == r) & (r != '0);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] r);
    if (writes(mem_slot, r)) return 2'd1;
    if (writes(wb_slot, r))  return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    // Only a definite 1 counts as taken; reset also masks it so the outputs
    // show their reset values while resetN is low.
    br_taken = resetN & (exBranchTaken === 1'b1);
    rs_used  = idValid & idUsesRs;
    rt_used  = idValid & idUsesRt;

    load_use  = 1'b0;
    raw_stall = 1'b0;
    if (FWD_EN) begin
      load_use = ex_slot.mem_read &
                 ((rs_used & writes(ex_slot, idRs)) | (rt_used & writes(ex_slot, idRt)));
    end else begin
      raw_stall = (rs_used & (writes(ex_slot, idRs) | writes(mem_slot, idRs))) |
                  (rt_used & (writes(ex_slot, idRt) | writes(mem_slot, idRt)));
      if (!WB_BYPASS)
        raw_stall = raw_stall | (rs_used & writes(wb_slot, idRs)) |
                    (rt_used & writes(wb_slot, idRt));
    end
    stall = (load_use | raw_stall) & ~br_taken;

    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExeFlush = 1'b0;
    if (br_taken) begin
      ifIdFlush  = 1'b1;
      idExeFlush = 1'b1;
    end else if (stall) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExeFlush = 1'b1;
    end

    fwdA = 2'd0;
    fwdB = 2'd0;
    if (FWD_EN && ex_slot.valid) begin
      fwdA = fwd_sel(ex_slot.rs);
      fwdB = fwd_sel(ex_slot.rt);
    end

    ex_next = '0;
    if (!idExeFlush) begin
      ex_next.valid     = idValid;
      ex_next.reg_write = idRegWrite;
      ex_next.write_reg = idWriteReg;
      ex_next.mem_read  = idMemRead;
      ex_next.rs        = idRs;
      ex_next.rt        = idRt;
    end
  end

  always_comb begin
    unused_fields = ^{mem_slot.mem_read, mem_slot.rs, mem_slot.rt,
                      wb_slot.mem_read, wb_slot.rs, wb_slot.rt};
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ex_slot    <= '0;
      mem_slot   <= '0;
      wb_slot    <= '0;
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      ex_slot  <= ex_next;
      mem_slot <= ex_slot;
      wb_slot  <= mem_slot;
      if (stall && stallCount != '1)
        stallCount <= stallCount + 1'b1;
      if (br_taken && flushCount != '1)
        flushCount <= flushCount + 1'b1;
    end
  end

endmodule
